// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, instruction layout and FSM state type for the alu op sequencer.
package alu_seq_pkg;

    localparam int INSTR_W = 11;
    localparam int IMM_W   = 4;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_XNOR = 3'd7;

    typedef enum logic {IDLE, HOLD} state_t;

    typedef struct packed {
        logic       ld;
        logic [2:0] sel;
        logic [1:0] dst;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       lsb;
    } instr_t;

    // Load immediates overlay the low four bits of the operand fields.
    function automatic logic [IMM_W-1:0] imm_of(instr_t i);
        return {i.ra[0], i.rb, i.lsb};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// alu: 4-bit combinational ALU; carry is add carry-out or subtract borrow, zero for logic ops.
module alu
    import alu_seq_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] sel,
    output logic [3:0] Y,
    output logic       carry
);
    logic [4:0] sum;
    logic [4:0] dif;

    assign sum = {1'b0, A} + {1'b0, B};
    assign dif = {1'b0, A} - {1'b0, B};

    always_comb begin
        Y     = '0;
        carry = 1'b0;
        case (sel)
            ALU_ADD:  {carry, Y} = sum;
            ALU_SUB:  {carry, Y} = dif;
            ALU_AND:  Y = A & B;
            ALU_OR:   Y = A | B;
            ALU_XOR:  Y = A ^ B;
            ALU_NAND: Y = ~(A & B);
            ALU_NOR:  Y = ~(A | B);
            default:  Y = ~(A ^ B);
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready ALU command front-end with 4x4 regfile and registered result stream.
// Define ALU_SEQ_ZERO_FLAG_EN to add the registered out_zero result flag.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [3:0] RESET_VAL = 4'h0,
    parameter int         CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_dst,
    output logic [3:0]         out_y,
    output logic               out_carry,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic               out_zero,
`endif
    output logic [CNT_W-1:0]   retired
);
    state_t           state_q, state_d;
    logic [3:0]       regs_q [4];
    logic [1:0]       dst_q;
    logic [3:0]       y_q, y_d, alu_y;
    logic             carry_q, carry_d, alu_c;
    logic [CNT_W-1:0] retired_q;
    logic             accept, fire;
    instr_t           ins;

    assign ins = instr_t'(in_instr);

    alu u_alu (
        .A     (regs_q[ins.ra]),
        .B     (regs_q[ins.rb]),
        .sel   (ins.sel),
        .Y     (alu_y),
        .carry (alu_c)
    );

    always_comb begin
        in_ready = !rst && (state_q == IDLE || out_ready);
        accept   = in_valid && in_ready;
        fire     = (state_q == HOLD) && out_ready;
        y_d      = ins.ld ? imm_of(ins) : alu_y;
        carry_d  = !ins.ld && alu_c;
        state_d  = accept ? HOLD : (fire ? IDLE : state_q);
    end

    // Operands are read from the pre-edge regfile; the write lands at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            y_q       <= '0;
            carry_q   <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q <= state_d;
            if (accept) begin
                regs_q[ins.dst] <= y_d;
                dst_q           <= ins.dst;
                y_q             <= y_d;
                carry_q         <= carry_d;
            end
            if (fire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign out_valid = state_q == HOLD;
    assign out_dst   = dst_q;
    assign out_y     = y_q;
    assign out_carry = carry_q;
    assign retired   = retired_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst) zero_q <= 1'b0;
        else if (accept) zero_q <= y_d == 4'h0;
    end

    assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer.
module tb_alu_op_sequencer;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_carry;
    logic [10:0] in_instr;
    logic [1:0]  out_dst;
    logic [3:0]  out_y;
    logic [7:0]  retired;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        out_zero;
`endif
    int npass = 0;
    int ntot  = 0;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dst   (out_dst),
        .out_y     (out_y),
        .out_carry (out_carry),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .retired   (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] op(input logic [2:0] sel, input logic [1:0] dst, ra, rb);
        return {1'b0, sel, dst, ra, rb, 1'b0};
    endfunction

    function automatic logic [10:0] ldi(input logic [1:0] dst, input logic [3:0] imm);
        return {1'b1, 3'b000, dst, 1'b0, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [10:0] instr);
        in_valid  = 1'b1;
        in_instr  = instr;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = ldi(2'd0, 4'h5);
        #1;
        ntot++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else npass++;
        tick();
        ntot++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else npass++;
        ntot++; if ({out_dst, out_y, out_carry} !== 7'd0) $display("FAIL reset_out got %h/%h/%b want 0", out_dst, out_y, out_carry); else npass++;
        ntot++; if (retired !== 8'd0) $display("FAIL reset_retired got %0d want 0", retired); else npass++;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        ntot++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", in_ready); else npass++;
    endtask

    task automatic test_add();
        do_reset();
        issue(ldi(2'd0, 4'h9));
        issue(ldi(2'd1, 4'h8));
        issue(op(3'd0, 2'd2, 2'd0, 2'd1));
        ntot++; if ({out_valid, out_dst, out_y, out_carry} !== {1'b1, 2'd2, 4'h1, 1'b1}) $display("FAIL add got v%b d%0d y%h c%b want v1 d2 y1 c1", out_valid, out_dst, out_y, out_carry); else npass++;
        drain();
        ntot++; if (retired !== 8'd3) $display("FAIL add_retired got %0d want 3", retired); else npass++;
        ntot++; if (out_valid !== 1'b0) $display("FAIL add_idle got %b want 0", out_valid); else npass++;
        issue(op(3'd3, 2'd3, 2'd2, 2'd2));
        ntot++; if ({out_y, out_carry} !== {4'h1, 1'b0}) $display("FAIL add_reg2 got %h/%b want 1/0", out_y, out_carry); else npass++;
        issue(op(3'd0, 2'd0, 2'd0, 2'd0));
        ntot++; if ({out_y, out_carry} !== {4'h2, 1'b1}) $display("FAIL self_dep got %h/%b want 2/1", out_y, out_carry); else npass++;
    endtask

    task automatic test_sub();
        do_reset();
        issue(ldi(2'd0, 4'h3));
        ntot++; if ({out_y, out_carry} !== {4'h3, 1'b0}) $display("FAIL ld_imm got %h/%b want 3/0", out_y, out_carry); else npass++;
        issue(ldi(2'd1, 4'h5));
        issue(op(3'd1, 2'd3, 2'd0, 2'd1));
        ntot++; if ({out_dst, out_y, out_carry} !== {2'd3, 4'hE, 1'b1}) $display("FAIL sub_borrow got %0d/%h/%b want 3/e/1", out_dst, out_y, out_carry); else npass++;
        issue(op(3'd1, 2'd3, 2'd1, 2'd0));
        ntot++; if ({out_y, out_carry} !== {4'h2, 1'b0}) $display("FAIL sub_pos got %h/%b want 2/0", out_y, out_carry); else npass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        issue(ldi(2'd0, 4'h7));
        in_valid = 1'b1; in_instr = ldi(2'd1, 4'h4); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            ntot++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); else npass++;
            tick();
            ntot++; if ({out_valid, out_dst, out_y, retired} !== {1'b1, 2'd0, 4'h7, 8'd0}) $display("FAIL bp_hold[%0d] got v%b d%0d y%h r%0d want v1 d0 y7 r0", i, out_valid, out_dst, out_y, retired); else npass++;
        end
        out_ready = 1'b1;
        #1;
        ntot++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else npass++;
        tick();
        ntot++; if ({out_valid, out_dst, out_y, retired} !== {1'b1, 2'd1, 4'h4, 8'd1}) $display("FAIL bp_next got v%b d%0d y%h r%0d want v1 d1 y4 r1", out_valid, out_dst, out_y, retired); else npass++;
        in_instr = ldi(2'd2, 4'h5);
        tick();
        ntot++; if ({out_valid, out_dst, out_y, retired} !== {1'b1, 2'd2, 4'h5, 8'd2}) $display("FAIL bp_stream got v%b d%0d y%h r%0d want v1 d2 y5 r2", out_valid, out_dst, out_y, retired); else npass++;
        in_valid = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        issue(op(3'd4, 2'd1, 2'd0, 2'd0));
        ntot++; if (out_zero !== 1'b1) $display("FAIL zero_set got %b want 1", out_zero); else npass++;
        out_ready = 1'b0;
        tick(); tick();
        ntot++; if (out_zero !== 1'b1) $display("FAIL zero_hold got %b want 1", out_zero); else npass++;
        issue(ldi(2'd1, 4'h1));
        ntot++; if (out_zero !== 1'b0) $display("FAIL zero_clr got %b want 0", out_zero); else npass++;
`endif
    endtask

    task automatic test_all_ops();
        logic [3:0] exp_y [8] = '{4'h6, 4'h2, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9};
        do_reset();
        issue(ldi(2'd0, 4'hC));
        issue(ldi(2'd1, 4'hA));
        for (int s = 0; s < 8; s++) begin
            issue(op(3'(s), 2'd2, 2'd0, 2'd1));
            ntot++; if ({out_y, out_carry} !== {exp_y[s], s == 0}) $display("FAIL op%0d got %h/%b want %h/%b", s, out_y, out_carry, exp_y[s], s == 0); else npass++;
        end
    endtask

    task automatic test_reset_mid();
        issue(ldi(2'd3, 4'hF));
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        ntot++; if ({out_valid, retired} !== {1'b0, 8'd0}) $display("FAIL mid_rst got v%b r%0d want v0 r0", out_valid, retired); else npass++;
        issue(op(3'd3, 2'd0, 2'd2, 2'd3));
        ntot++; if ({out_y, out_carry} !== {4'h0, 1'b0}) $display("FAIL mid_rst_regs got %h/%b want 0/0", out_y, out_carry); else npass++;
        issue(op(3'd0, 2'd1, 2'd0, 2'd1));
        ntot++; if (out_y !== 4'h0) $display("FAIL mid_rst_regs01 got %h want 0", out_y); else npass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) issue(ldi(2'(i), 4'(i)));
        ntot++; if (retired !== 8'd255) $display("FAIL wrap_pre got %0d want 255", retired); else npass++;
        drain();
        ntot++; if (retired !== 8'd0) $display("FAIL wrap got %0d want 0", retired); else npass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_all_ops();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
